l2_cache_control: RTL and testbench

L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

---
 rtl/lc3b_types.sv | 34 +++
 rtl/l2_cache_control_if.sv | 40 ++++
 rtl/plru_update.sv | 21 ++
 rtl/l2_cache_control.sv | 129 ++++++++++++
 tb/tb_l2_cache_control.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared types for the L2 cache controller: FSM states, PLRU bit positions and
// helpers for decoding the per-way hit vector.
package lc3b_types;

  typedef enum logic [1:0] {
    StIdle,
    StTagCheck,
    StWriteback,
    StFill
  } l2_state_e;

  typedef logic [1:0] way_t;
  typedef logic [2:0] plru_t;

  // Tree PLRU: root chooses the a/b or c/d pair, the leaves choose within a pair.
  localparam int unsigned PlruRoot = 0;
  localparam int unsigned PlruAb   = 1;
  localparam int unsigned PlruCd   = 2;

  // Lowest-index way among the set hit bits.
  function automatic way_t first_hit(input logic [3:0] hit);
    way_t w;
    w = '0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) w = way_t'(i);
    end
    return w;
  endfunction

  function automatic logic multi_hit(input logic [3:0] hit);
    return (hit & (hit - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/l2_cache_control_if.sv
// Request, downstream memory and datapath-control signals of the L2 controller.
// slave is the controller's view; master is the surrounding cache/datapath.
interface l2_cache_control_if;
  import lc3b_types::*;

  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic [3:0] hit;
  logic       valid_v;
  logic       dirty_v;
  way_t       victim_way;
  plru_t      lru_in;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;
  logic       pmem_addr_sel;
  way_t       way_sel;
  logic       load_data;
  logic       load_tag;
  logic       set_valid;
  logic       set_dirty;
  logic       clear_dirty;
  logic       data_src;
  logic       lru_we;
  plru_t      lru_next;

  modport slave (
    input  mem_read, mem_write, hit, valid_v, dirty_v, victim_way, lru_in, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, load_data, load_tag,
           set_valid, set_dirty, clear_dirty, data_src, lru_we, lru_next
  );

  modport master (
    output mem_read, mem_write, hit, valid_v, dirty_v, victim_way, lru_in, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, load_data, load_tag,
           set_valid, set_dirty, clear_dirty, data_src, lru_we, lru_next
  );

endinterface

// File: rtl/plru_update.sv
// 4-way tree pseudo-LRU update: point the touched tree bits away from the
// accessed way and keep the untouched leaf.
module plru_update
  import lc3b_types::*;
(
  input  way_t  way,
  input  plru_t lru_in,
  output plru_t lru_next
);

  always_comb begin
    lru_next           = lru_in;
    lru_next[PlruRoot] = way[1];
    if (way[1]) begin
      lru_next[PlruCd] = way[0];
    end else begin
      lru_next[PlruAb] = way[0];
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: tag check, dirty-victim writeback, line fill, PLRU update
// and saturating hit/miss/writeback statistics.
module l2_cache_control
  import lc3b_types::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  l2_cache_control_if.slave   bus,
  output logic [CntWidth-1:0] hit_cnt,
  output logic [CntWidth-1:0] miss_cnt,
  output logic [CntWidth-1:0] wb_cnt,
  output logic                multi_hit_err
);

  l2_state_e state_q;
  way_t      victim_q;
  way_t      hit_way;
  plru_t     plru_out;
  logic      req;
  logic      victim_dirty;
  logic      tc_hit;
  logic      tc_miss;

  assign req          = bus.mem_read | bus.mem_write;
  assign victim_dirty = bus.valid_v & bus.dirty_v;
  assign hit_way      = first_hit(bus.hit);
  assign tc_hit       = (state_q == StTagCheck) && req && (|bus.hit);
  assign tc_miss      = (state_q == StTagCheck) && req && !(|bus.hit);

  plru_update u_plru_update (
    .way      (hit_way),
    .lru_in   (bus.lru_in),
    .lru_next (plru_out)
  );

  // A request withdrawn during a miss still finishes the pending pmem transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      victim_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) state_q <= StTagCheck;
        end
        StTagCheck: begin
          if (tc_miss) begin
            victim_q <= bus.victim_way;
            state_q  <= victim_dirty ? StWriteback : StFill;
          end else begin
            state_q <= StIdle;
          end
        end
        StWriteback: begin
          if (bus.pmem_resp) state_q <= req ? StFill : StIdle;
        end
        StFill: begin
          if (bus.pmem_resp) state_q <= req ? StTagCheck : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
      multi_hit_err <= 1'b0;
    end else begin
      if (tc_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (tc_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      if (tc_miss && victim_dirty && wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
      if (tc_hit && multi_hit(bus.hit)) multi_hit_err <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.way_sel       = '0;
    bus.load_data     = 1'b0;
    bus.load_tag      = 1'b0;
    bus.set_valid     = 1'b0;
    bus.set_dirty     = 1'b0;
    bus.clear_dirty   = 1'b0;
    bus.data_src      = 1'b0;
    bus.lru_we        = 1'b0;
    bus.lru_next      = '0;
    unique case (state_q)
      StTagCheck: begin
        if (tc_hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_we   = 1'b1;
          bus.lru_next = plru_out;
          bus.way_sel  = hit_way;
          // Simultaneous read and write requests resolve as a write.
          if (bus.mem_write) begin
            bus.load_data = 1'b1;
            bus.set_dirty = 1'b1;
          end
        end
      end
      StWriteback: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = victim_q;
      end
      StFill: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.load_data   = 1'b1;
          bus.load_tag    = 1'b1;
          bus.set_valid   = 1'b1;
          bus.clear_dirty = 1'b1;
          bus.data_src    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: directed corner cases plus random traffic checked
// against a one-set, four-way cache model with tree PLRU replacement.
module tb_l2_cache_control;

  localparam int unsigned CntW   = 10;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk;
  logic            reset_n;
  logic [CntW-1:0] hit_cnt, miss_cnt, wb_cnt;
  logic            multi_hit_err;

  l2_cache_control_if bus ();

  l2_cache_control #(.CntWidth(CntW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt),
    .multi_hit_err (multi_hit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the single addressed set.
  logic [3:0] m_tag[4];
  bit         m_valid[4];
  bit         m_dirty[4];
  logic [2:0] m_lru;
  int         m_hits, m_miss, m_wb;

  function automatic int sat(input int n);
    return (n > CntMax) ? CntMax : n;
  endfunction

  function automatic logic [2:0] plru_next(input int w, input logic [2:0] l);
    logic [2:0] r;
    r    = l;
    r[0] = (w >= 2);
    if (w >= 2) r[2] = (w % 2 == 1);
    else        r[1] = (w % 2 == 1);
    return r;
  endfunction

  function automatic int plru_victim(input logic [2:0] l);
    if (l[0]) return l[1] ? 0 : 1;
    return l[2] ? 2 : 3;
  endfunction

  function automatic int lowest(input logic [3:0] hv);
    for (int i = 0; i < 4; i++) if (hv[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] strobes();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_data, bus.load_tag,
            bus.set_valid, bus.set_dirty, bus.clear_dirty, bus.data_src, bus.lru_we,
            bus.pmem_addr_sel, bus.lru_next};
  endfunction

  task automatic clear_inputs();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.hit        = '0;
    bus.valid_v    = 1'b0;
    bus.dirty_v    = 1'b0;
    bus.victim_way = '0;
    bus.lru_in     = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_tag[i]   = '0;
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_lru  = '0;
    m_hits = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check("rst_counters", {hit_cnt, miss_cnt, wb_cnt, multi_hit_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, sat(m_hits));
    check({tag, "_miss_cnt"}, miss_cnt, sat(m_miss));
    check({tag, "_wb_cnt"}, wb_cnt, sat(m_wb));
  endtask

  // Raw single hit with explicit inputs and spec-derived expectations.
  task automatic raw_hit(input bit wr, input logic [3:0] hv, input logic [2:0] lru,
                         input logic [1:0] exp_way, input logic [2:0] exp_lru);
    @(negedge clk);
    bus.mem_write = wr;
    bus.mem_read  = 1'b1;
    bus.hit       = hv;
    bus.lru_in    = lru;
    #1 check("raw_idle", strobes(), 0);
    @(negedge clk); #1;
    check("raw_resp", {bus.mem_resp, bus.lru_we, bus.load_data, bus.set_dirty, bus.data_src},
          {2'b11, wr, wr, 1'b0});
    check("raw_way", bus.way_sel, exp_way);
    check("raw_lru_next", bus.lru_next, exp_lru);
    @(negedge clk);
    clear_inputs();
    #1 check("raw_back_idle", strobes(), 0);
  endtask

  task automatic do_req(input bit wr, input logic [3:0] tag, input bit abandon);
    logic [3:0] hv;
    int         v, w, n;
    bit         wb, done;
    hv   = '0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == tag) hv[i] = 1'b1;
    v  = plru_victim(m_lru);
    wb = m_valid[v] && m_dirty[v];
    @(negedge clk);
    bus.mem_write  = wr;
    bus.mem_read   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.hit        = hv;
    bus.lru_in     = m_lru;
    bus.victim_way = 2'(v);
    bus.valid_v    = m_valid[v];
    bus.dirty_v    = m_dirty[v];
    #1 check("req_idle", strobes(), 0);
    @(negedge clk); #1;
    if (hv == 0) begin
      m_miss++;
      if (wb) m_wb++;
      check("miss_tc", {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.lru_we}, 0);
      if (wb) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          @(negedge clk); #1;
          check("wb_req", {bus.pmem_write, bus.pmem_addr_sel, bus.pmem_read, bus.load_data,
                           bus.way_sel}, {4'b1100, 2'(v)});
        end
        bus.pmem_resp = 1'b1;
        #1 check("wb_resp", {bus.pmem_write, bus.load_data, bus.mem_resp}, 3'b100);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1 check("fill_req", {bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel}, 3'b100);
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        @(negedge clk); #1;
        check("fill_wait", {bus.pmem_read, bus.load_data, bus.way_sel}, {2'b10, 2'(v)});
      end
      if (abandon) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
      bus.pmem_resp = 1'b1;
      #1;
      check("fill_strobes", {bus.load_data, bus.load_tag, bus.set_valid, bus.clear_dirty,
                             bus.data_src, bus.set_dirty, bus.mem_resp}, 7'b1111100);
      check("fill_way", bus.way_sel, v);
      m_tag[v]   = tag;
      m_valid[v] = 1'b1;
      m_dirty[v] = 1'b0;
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (abandon) begin
        #1 check("abandon_idle", strobes(), 0);
        done = 1'b1;
      end else begin
        hv         = 4'b0001 << v;
        bus.hit    = hv;
        bus.lru_in = m_lru;
        #1;
      end
    end
    if (!done) begin
      w = lowest(hv);
      check("hit_resp", {bus.mem_resp, bus.lru_we, bus.load_data, bus.set_dirty, bus.data_src,
                         bus.load_tag, bus.pmem_read}, {2'b11, wr, wr, 3'b000});
      check("hit_way", bus.way_sel, w);
      check("hit_lru_next", bus.lru_next, plru_next(w, m_lru));
      m_hits++;
      m_lru = plru_next(w, m_lru);
      if (wr) m_dirty[w] = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1 check("hit_back_idle", strobes(), 0);
    end
    // A stray pmem_resp while idle must have no effect.
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1 check("stray_resp", strobes(), 0);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1 check("stray_resp_after", strobes(), 0);
    end
    check_counters("txn");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with busy-looking inputs applied.
    reset_n = 1'b0;
    clear_inputs();
    bus.mem_read  = 1'b1;
    bus.hit       = 4'b1111;
    bus.lru_in    = 3'b111;
    bus.pmem_resp = 1'b1;
    #2;
    check("reset_strobes", strobes(), 0);
    check("reset_counters", {hit_cnt, miss_cnt, wb_cnt, multi_hit_err}, 0);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    clear_model();

    // Read hit way c with lru 000.
    raw_hit(1'b0, 4'b0100, 3'b000, 2'd2, 3'b001);
    check("c_hit_cnt", hit_cnt, 1);
    check("c_no_err", multi_hit_err, 0);
    // Multi-hit write picks way b and latches the error.
    raw_hit(1'b1, 4'b0110, 3'b101, 2'd1, 3'b110);
    check("multi_err_set", multi_hit_err, 1);
    raw_hit(1'b0, 4'b0001, 3'b111, 2'd0, 3'b100);
    check("multi_err_sticky", multi_hit_err, 1);
    check("multi_hit_cnt", hit_cnt, 3);

    reset_dut();
    check("err_cleared", multi_hit_err, 0);

    for (int t = 0; t < 250; t++) begin
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    end

    // Reset asserted mid-fill aborts without waiting for a clock edge.
    reset_dut();
    @(negedge clk);
    bus.mem_read   = 1'b1;
    bus.victim_way = 2'd2;
    @(negedge clk);
    @(negedge clk); #1;
    check("pre_rst_fill", {bus.pmem_read, bus.way_sel}, 3'b110);
    #2 reset_n = 1'b0;
    #1 check("async_rst_pmem_read", strobes(), 0);
    check("async_rst_counters", {hit_cnt, miss_cnt}, 0);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    bus.pmem_resp = 1'b1;
    #1 check("post_rst_resp", strobes(), 0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1 check("post_rst_idle", strobes(), 0);

    // Hit counter saturation.
    reset_dut();
    bus.mem_read = 1'b1;
    bus.hit      = 4'b0001;
    for (int i = 0; i < 2 * (CntMax + 80); i++) begin
      @(negedge clk);
      if (i == 400) check("sat_mid_cnt", hit_cnt, 200);
    end
    clear_inputs();
    @(negedge clk); #1;
    check("sat_hit_cnt", hit_cnt, CntMax);
    check("sat_miss_cnt", miss_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
